invader_swarm_ctrl: RTL and testbench

INVADER_SWARM_CTRL -- requirements
Module: invader_swarm_ctrl

---
 rtl/invader_swarm_ctrl.sv | 155 +++++++++++++++
 tb/tb_invader_swarm_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_swarm_ctrl.sv
// Formation controller for the invader swarm: marches the block sideways on a
// population-dependent interval, descends at the playfield edges, and detects landing/clearing.
module invader_swarm_ctrl #(
    parameter int unsigned X_INIT     = 32,
    parameter int unsigned Y_INIT     = 64,
    parameter int unsigned X_STEP     = 4,
    parameter int unsigned Y_STEP     = 32,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 1023,
    parameter int unsigned Y_LIMIT    = 700,
    parameter int unsigned MIN_PERIOD = 65_000,
    parameter int unsigned PER_ALIVE  = 75_000
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       game_start,
    input  logic       pause,
    input  logic [5:0] alive_cnt,
    input  logic [9:0] col_min_off,
    input  logic [9:0] col_max_off,
    input  logic [9:0] row_max_off,
    output logic [9:0] x_off,
    output logic [9:0] y_off,
    output logic       dir,
    output logic       anim_frame,
    output logic       step_pulse,
    output logic       landed,
    output logic       cleared,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_CLEARED = 2'd2,
        S_LANDED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [9:0]  x_off_q, x_off_d;
    logic [9:0]  y_off_q, y_off_d;
    logic        dir_q, dir_d;
    logic        anim_q, anim_d;
    logic        step_q, step_d;
    logic        landed_q, landed_d;
    logic        cleared_q, cleared_d;

    logic [31:0] period, period_m1;
    logic [10:0] right_sum, left_sum, y_sum, land_sum;
    logic [9:0]  y_desc, x_left;
    logic        right_hit, left_hit, land_hit, tick;

    // Period follows alive_cnt live; >= lets a shrinking period fire immediately.
    always_comb begin
        period    = 32'(MIN_PERIOD) + 32'(alive_cnt) * 32'(PER_ALIVE);
        period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
        tick      = (state_q == S_RUN) && !pause && (cnt_q >= period_m1);
    end

    // Edge and landing arithmetic in 11 bits so no sum can wrap back into range.
    always_comb begin
        right_sum = {1'b0, x_off_q} + {1'b0, col_max_off} + 11'(X_STEP);
        left_sum  = {1'b0, x_off_q} + {1'b0, col_min_off};
        right_hit = right_sum > 11'(X_MAX);
        left_hit  = left_sum < 11'(X_MIN + X_STEP);
        y_sum     = {1'b0, y_off_q} + 11'(Y_STEP);
        y_desc    = y_sum[10] ? 10'h3ff : y_sum[9:0];
        land_sum  = {1'b0, y_desc} + {1'b0, row_max_off};
        land_hit  = land_sum >= 11'(Y_LIMIT);
        x_left    = (x_off_q >= 10'(X_STEP)) ? x_off_q - 10'(X_STEP) : 10'd0;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_off_d   = x_off_q;
        y_off_d   = y_off_q;
        dir_d     = dir_q;
        anim_d    = anim_q;
        step_d    = 1'b0;
        landed_d  = landed_q;
        cleared_d = cleared_q;

        if (game_start) begin
            state_d   = S_RUN;
            cnt_d     = 32'd0;
            x_off_d   = 10'(X_INIT);
            y_off_d   = 10'(Y_INIT);
            dir_d     = 1'b1;
            anim_d    = 1'b0;
            landed_d  = 1'b0;
            cleared_d = 1'b0;
        end else if (state_q == S_RUN && !pause) begin
            if (!tick) begin
                cnt_d = cnt_q + 32'd1;
            end else begin
                cnt_d = 32'd0;
                if (alive_cnt == 6'd0) begin
                    state_d   = S_CLEARED;
                    cleared_d = 1'b1;
                end else begin
                    step_d = 1'b1;
                    anim_d = ~anim_q;
                    if ((dir_q && right_hit) || (!dir_q && left_hit)) begin
                        y_off_d = y_desc;
                        dir_d   = ~dir_q;
                        if (land_hit) begin
                            state_d  = S_LANDED;
                            landed_d = 1'b1;
                        end
                    end else if (dir_q) begin
                        x_off_d = x_off_q + 10'(X_STEP);
                    end else begin
                        x_off_d = x_left;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 32'd0;
            x_off_q   <= 10'(X_INIT);
            y_off_q   <= 10'(Y_INIT);
            dir_q     <= 1'b1;
            anim_q    <= 1'b0;
            step_q    <= 1'b0;
            landed_q  <= 1'b0;
            cleared_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            x_off_q   <= x_off_d;
            y_off_q   <= y_off_d;
            dir_q     <= dir_d;
            anim_q    <= anim_d;
            step_q    <= step_d;
            landed_q  <= landed_d;
            cleared_q <= cleared_d;
        end
    end

    assign x_off      = x_off_q;
    assign y_off      = y_off_q;
    assign dir        = dir_q;
    assign anim_frame = anim_q;
    assign step_pulse = step_q;
    assign landed     = landed_q;
    assign cleared    = cleared_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_invader_swarm_ctrl.sv
// Bench for invader_swarm_ctrl with short periods and a narrow playfield so that
// marching, descending, landing and clearing all happen within a few hundred clocks.
module tb_invader_swarm_ctrl;

    localparam int X_INIT = 32, Y_INIT = 64, X_STEP = 4, Y_STEP = 32, X_MIN = 0;
    localparam int X_MAX = 100, Y_LIMIT = 200, MIN_PERIOD = 4, PER_ALIVE = 1;
    localparam int W = 23;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_CLEARED = 2'd2, ST_LANDED = 2'd3;

    logic       clk65MHz = 1'b0;
    logic       rst = 1'b1;
    logic       game_start = 1'b0;
    logic       pause = 1'b0;
    logic [5:0] alive_cnt = 6'd10;
    logic [9:0] col_min_off = 10'd0;
    logic [9:0] col_max_off = 10'd0;
    logic [9:0] row_max_off = 10'd0;
    logic [9:0] x_off, y_off;
    logic       dir, anim_frame, step_pulse, landed, cleared;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int mx, my, mdir, manim, mlanded;

    invader_swarm_ctrl #(
        .X_INIT(X_INIT), .Y_INIT(Y_INIT), .X_STEP(X_STEP), .Y_STEP(Y_STEP),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_LIMIT(Y_LIMIT),
        .MIN_PERIOD(MIN_PERIOD), .PER_ALIVE(PER_ALIVE)
    ) dut (
        .clk65MHz(clk65MHz), .rst(rst), .game_start(game_start), .pause(pause),
        .alive_cnt(alive_cnt), .col_min_off(col_min_off), .col_max_off(col_max_off),
        .row_max_off(row_max_off), .x_off(x_off), .y_off(y_off), .dir(dir),
        .anim_frame(anim_frame), .step_pulse(step_pulse), .landed(landed),
        .cleared(cleared), .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 clk65MHz = ~clk65MHz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick_edge();
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic wait_pulse(input int budget, output int cycles, output bit seen);
        seen = 1'b0;
        cycles = 0;
        while (cycles < budget && !seen) begin
            tick_edge();
            cycles++;
            if (step_pulse) seen = 1'b1;
        end
    endtask

    task automatic start_game();
        game_start = 1'b1;
        tick_edge();
        game_start = 1'b0;
        mx = X_INIT; my = Y_INIT; mdir = 1; manim = 0; mlanded = 0;
    endtask

    // Reference model of one movement tick; pushes the expected outcome.
    task automatic model_tick();
        bit descend;
        descend = 1'b0;
        if (mdir == 1) begin
            if (mx + int'(col_max_off) + X_STEP > X_MAX) descend = 1'b1;
            else mx = mx + X_STEP;
        end else begin
            if (mx + int'(col_min_off) < X_MIN + X_STEP) descend = 1'b1;
            else mx = mx - X_STEP;
        end
        if (descend) begin
            my = my + Y_STEP;
            mdir = 1 - mdir;
            if (my + int'(row_max_off) >= Y_LIMIT) mlanded = 1;
        end
        manim = 1 - manim;
        exp_q.push_back({10'(mx), 10'(my), 1'(mdir), 1'(manim), 1'(mlanded)});
    endtask

    function automatic logic [W-1:0] observed();
        return {x_off, y_off, dir, anim_frame, landed};
    endfunction

    // Tests
    task automatic test_reset();
        logic [W-1:0] e;
        int cyc;
        bit seen;
        rst = 1'b1;
        game_start = 1'b1;
        repeat (3) tick_edge();
        e = {10'(X_INIT), 10'(Y_INIT), 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (observed() !== e || step_pulse !== 1'b0 || cleared !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_values: got %h st=%0d sp=%b cl=%b want %h st=%0d", observed(), dbg_state, step_pulse, cleared, e, ST_IDLE);
        end
        rst = 1'b0;
        game_start = 1'b0;
        wait_pulse(30, cyc, seen);
        n_cmp++;
        if (seen || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL idle_hold: got pulse=%b st=%0d want pulse=0 st=%0d", seen, dbg_state, ST_IDLE);
        end
    endtask

    task automatic test_march();
        logic [W-1:0] e;
        int cyc;
        bit seen;
        alive_cnt = 6'd10;
        col_min_off = 10'd0;
        col_max_off = 10'd0;
        row_max_off = 10'd0;
        start_game();
        n_cmp++;
        if (dbg_state !== ST_RUN || x_off !== 10'(X_INIT) || y_off !== 10'(Y_INIT)) begin
            n_bad++;
            $display("FAIL start_state: got st=%0d x=%0d y=%0d want st=%0d x=%0d y=%0d", dbg_state, x_off, y_off, ST_RUN, X_INIT, Y_INIT);
        end
        for (int i = 0; i < 3; i++) begin
            model_tick();
            wait_pulse(40, cyc, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || cyc != 14) begin
                n_bad++;
                $display("FAIL march_interval[%0d]: got seen=%b clocks=%0d want 14", i, seen, cyc);
            end
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL march_offsets[%0d]: got %h want %h", i, observed(), e);
            end
        end
        tick_edge();
        n_cmp++;
        if (step_pulse !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width: got step_pulse=%b want 0", step_pulse);
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] e;
        int cyc;
        bit seen;
        start_game();
        model_tick();
        wait_pulse(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || observed() !== e) begin
            n_bad++;
            $display("FAIL pause_pre: got seen=%b %h want %h", seen, observed(), e);
        end
        repeat (5) tick_edge();
        pause = 1'b1;
        repeat (50) tick_edge();
        n_cmp++;
        if (step_pulse !== 1'b0 || observed() !== e) begin
            n_bad++;
            $display("FAIL pause_frozen: got sp=%b %h want sp=0 %h", step_pulse, observed(), e);
        end
        pause = 1'b0;
        model_tick();
        wait_pulse(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || cyc != 9) begin
            n_bad++;
            $display("FAIL pause_delay: got seen=%b clocks=%0d want 9 (64 total)", seen, cyc);
        end
        n_cmp++;
        if (observed() !== e) begin
            n_bad++;
            $display("FAIL pause_offsets: got %h want %h", observed(), e);
        end
    endtask

    task automatic test_restart_priority();
        logic [W-1:0] e;
        int cyc;
        bit seen;
        start_game();
        model_tick();
        wait_pulse(40, cyc, seen);
        void'(exp_q.pop_front());
        repeat (13) tick_edge();
        start_game();
        e = {10'(X_INIT), 10'(Y_INIT), 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (observed() !== e || step_pulse !== 1'b0 || dbg_state !== ST_RUN) begin
            n_bad++;
            $display("FAIL restart_priority: got %h sp=%b st=%0d want %h sp=0 st=%0d", observed(), step_pulse, dbg_state, e, ST_RUN);
        end
        model_tick();
        wait_pulse(40, cyc, seen);
        e = exp_q.pop_front();
        n_cmp++;
        if (!seen || cyc != 14 || observed() !== e) begin
            n_bad++;
            $display("FAIL restart_next: got seen=%b clocks=%0d %h want 14 %h", seen, cyc, observed(), e);
        end
    endtask

    task automatic test_edges_and_landing();
        logic [W-1:0] e;
        int cyc;
        int ticks;
        bit seen;
        int descents;
        col_min_off = 10'd0;
        col_max_off = 10'd61;
        row_max_off = 10'd40;
        start_game();
        ticks = 0;
        descents = 0;
        while (mlanded == 0 && ticks < 40) begin
            int py;
            py = my;
            model_tick();
            if (my != py) descents++;
            wait_pulse(40, cyc, seen);
            e = exp_q.pop_front();
            n_cmp++;
            if (!seen || cyc != 14 || observed() !== e) begin
                n_bad++;
                $display("FAIL edge_tick[%0d]: got seen=%b clocks=%0d %h want 14 %h", ticks, seen, cyc, observed(), e);
            end
            ticks++;
        end
        n_cmp++;
        if (descents != 3 || y_off !== 10'd160 || landed !== 1'b1 || dbg_state !== ST_LANDED) begin
            n_bad++;
            $display("FAIL landing: got descents=%0d y=%0d landed=%b st=%0d want 3 160 1 %0d", descents, y_off, landed, dbg_state, ST_LANDED);
        end
        wait_pulse(40, cyc, seen);
        n_cmp++;
        if (seen || observed() !== e) begin
            n_bad++;
            $display("FAIL landed_frozen: got pulse=%b %h want pulse=0 %h", seen, observed(), e);
        end
    endtask

    task automatic test_cleared();
        logic [W-1:0] e;
        int cyc;
        bit pulsed;
        col_max_off = 10'd0;
        row_max_off = 10'd0;
        alive_cnt = 6'd10;
        start_game();
        model_tick();
        wait_pulse(40, cyc, pulsed);
        e = exp_q.pop_front();
        alive_cnt = 6'd0;
        cyc = 0;
        pulsed = 1'b0;
        while (cyc < 40 && !cleared) begin
            tick_edge();
            cyc++;
            if (step_pulse) pulsed = 1'b1;
        end
        n_cmp++;
        if (cyc != 4 || cleared !== 1'b1 || pulsed || dbg_state !== ST_CLEARED) begin
            n_bad++;
            $display("FAIL cleared_tick: got clocks=%0d cl=%b pulse=%b st=%0d want 4 1 0 %0d", cyc, cleared, pulsed, dbg_state, ST_CLEARED);
        end
        n_cmp++;
        if (observed() !== e) begin
            n_bad++;
            $display("FAIL cleared_offsets: got %h want %h", observed(), e);
        end
        alive_cnt = 6'd10;
        start_game();
        n_cmp++;
        if (x_off !== 10'(X_INIT) || y_off !== 10'(Y_INIT) || cleared !== 1'b0 || dbg_state !== ST_RUN) begin
            n_bad++;
            $display("FAIL cleared_restart: got x=%0d y=%0d cl=%b st=%0d want %0d %0d 0 %0d", x_off, y_off, cleared, dbg_state, X_INIT, Y_INIT, ST_RUN);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] e;
        int cyc;
        bit seen;
        col_max_off = 10'd61;
        start_game();
        model_tick();
        wait_pulse(40, cyc, seen);
        void'(exp_q.pop_front());
        model_tick();
        wait_pulse(40, cyc, seen);
        void'(exp_q.pop_front());
        repeat (7) tick_edge();
        rst = 1'b1;
        tick_edge();
        rst = 1'b0;
        e = {10'(X_INIT), 10'(Y_INIT), 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (observed() !== e || step_pulse !== 1'b0 || cleared !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %h sp=%b cl=%b st=%0d want %h st=%0d", observed(), step_pulse, cleared, dbg_state, e, ST_IDLE);
        end
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_march();
        test_pause();
        test_restart_priority();
        test_edges_and_landing();
        test_cleared();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
